// File: rtl/wb2uart_host.sv
`default_nettype none
// ============================================================================
// Module      : wb2uart_host
// Description : Wishbone slave that turns each bus access into an ASCII
//               command line on a UART byte stream and parses the reply.
//               write -> "wm AAAAAAAA DDDDDDDD\n", read -> "rm AAAAAAAA\n".
//               The reply's hex digits (last 8, case-insensitive) are
//               collected up to LF; other reply bytes are ignored.
// Ports       : app_clk/arst_n      clock, async active-low reset
//               wbs_*               Wishbone slave (wbs_sel_i ignored)
//               tx_data_avail/tx_data/tx_rd   outgoing byte handshake
//               rx_ready/rx_wr/rx_data        incoming byte handshake
// Revision    : 1.0 - initial release
// ============================================================================
module wb2uart_host #(
  parameter int unsigned       TOUT_W   = 16,
  parameter logic [TOUT_W-1:0] TOUT_MAX = 16'hFFFF
) (
  input  logic        app_clk,
  input  logic        arst_n,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [31:0] wbs_adr_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        tx_data_avail,
  output logic [7:0]  tx_data,
  input  logic        tx_rd,
  output logic        rx_ready,
  input  logic        rx_wr,
  input  logic [7:0]  rx_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TX_CMD  = 2'd1,
    S_RX_RESP = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [7:0]        c_LF        = 8'h0A;
  localparam logic [7:0]        c_SP        = 8'h20;
  // Error fires on the cycle the counter would reach TOUT_MAX idle cycles.
  localparam logic [TOUT_W-1:0] c_TOUT_LAST = TOUT_MAX - 1'b1;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_adr;
  logic [31:0]       r_dat;
  logic              r_we;
  logic [4:0]        r_idx;
  logic [TOUT_W-1:0] r_tout;
  logic [31:0]       r_shreg;
  logic [31:0]       r_dat_o;
  logic              r_ack;
  logic              r_err;
  logic              r_rx_ready;

  logic              w_req;
  logic              w_last;
  logic              w_timeout;
  logic [7:0]        w_byte;
  logic [2:0]        w_adr_sel;
  logic [2:0]        w_dat_sel;
  logic [3:0]        w_adr_nib;
  logic [3:0]        w_dat_nib;
  logic              w_rx_hex;
  logic [3:0]        w_rx_nib;
  logic              w_unused;

  assign w_unused = &{1'b0, wbs_sel_i};

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h57 + {4'h0, n});
  endfunction

  assign w_req = wbs_cyc_i & wbs_stb_i;

  // Address digits sit at idx 3..10, data digits at idx 12..19; the nibble
  // number (7 = MSB) is a modulo-8 difference of the low index bits.
  assign w_adr_sel = 3'd2 - r_idx[2:0];
  assign w_dat_sel = 3'd3 - r_idx[2:0];
  assign w_adr_nib = r_adr[{w_adr_sel, 2'b00} +: 4];
  assign w_dat_nib = r_dat[{w_dat_sel, 2'b00} +: 4];
  assign w_last    = r_we ? (r_idx == 5'd20) : (r_idx == 5'd11);

  always_comb begin
    w_byte = 8'h00;
    if (r_idx == 5'd0)       w_byte = r_we ? 8'h77 : 8'h72;
    else if (r_idx == 5'd1)  w_byte = 8'h6D;
    else if (r_idx == 5'd2)  w_byte = c_SP;
    else if (r_idx <= 5'd10) w_byte = hex_char(w_adr_nib);
    else if (r_idx == 5'd11) w_byte = r_we ? c_SP : c_LF;
    else if (r_idx <= 5'd19) w_byte = hex_char(w_dat_nib);
    else if (r_idx == 5'd20) w_byte = c_LF;
  end

  always_comb begin
    w_rx_hex = 1'b1;
    w_rx_nib = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      w_rx_nib = rx_data[3:0];
    else if ((rx_data >= 8'h61 && rx_data <= 8'h66) ||
             (rx_data >= 8'h41 && rx_data <= 8'h46))
      w_rx_nib = rx_data[3:0] + 4'd9;
    else
      w_rx_hex = 1'b0;
  end

  assign w_timeout = (r_state == S_RX_RESP) && !rx_wr && (r_tout == c_TOUT_LAST);

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (w_req && !r_ack) w_next = S_TX_CMD;
      S_TX_CMD:  if (tx_rd && w_last) w_next = S_RX_RESP;
      S_RX_RESP: begin
        if (rx_wr && rx_data == c_LF) w_next = S_DONE;
        else if (w_timeout)           w_next = S_IDLE;
      end
      S_DONE:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge app_clk or negedge arst_n) begin
    if (!arst_n) begin
      r_adr      <= 32'h0;
      r_dat      <= 32'h0;
      r_we       <= 1'b0;
      r_idx      <= 5'd0;
      r_tout     <= '0;
      r_shreg    <= 32'h0;
      r_dat_o    <= 32'h0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rx_ready <= 1'b0;
    end else begin
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rx_ready <= (w_next == S_IDLE) || (w_next == S_RX_RESP);
      unique case (r_state)
        S_IDLE: begin
          if (w_req && !r_ack) begin
            r_adr <= wbs_adr_i;
            r_dat <= wbs_dat_i;
            r_we  <= wbs_we_i;
            r_idx <= 5'd0;
          end
        end
        S_TX_CMD: begin
          if (tx_rd) begin
            r_idx <= r_idx + 5'd1;
            if (w_last) begin
              r_tout  <= '0;
              r_shreg <= 32'h0;
            end
          end
        end
        S_RX_RESP: begin
          if (rx_wr) begin
            r_tout <= '0;
            if (w_rx_hex) r_shreg <= {r_shreg[27:0], w_rx_nib};
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_tout <= r_tout + 1'b1;
          end
        end
        S_DONE: begin
          if (!r_we) r_dat_o <= r_shreg;
          // A master that abandoned the cycle gets no ack.
          r_ack <= w_req;
        end
      endcase
    end
  end

  assign wbs_dat_o     = r_dat_o;
  assign wbs_ack_o     = r_ack;
  assign wbs_err_o     = r_err;
  assign rx_ready      = r_rx_ready;
  assign tx_data_avail = (r_state == S_TX_CMD);
  assign tx_data       = (r_state == S_TX_CMD) ? w_byte : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_wb2uart_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb2uart_host
// Description : Self-checking bench for wb2uart_host. Expected command lines
//               are formatted with $sformatf, expected read data by
//               collecting the reply's hex digits into a string and keeping
//               the last eight.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb2uart_host;

  logic        app_clk = 1'b0;
  logic        arst_n  = 1'b1;
  logic        wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [31:0] wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic [3:0]  wbs_sel_i = 4'hF;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_err_o, tx_data_avail, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_rd = 1'b0, rx_wr = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  int checks = 0;
  int passed = 0;
  logic [31:0] last_rd = 32'h0;

  wb2uart_host #(.TOUT_W(16), .TOUT_MAX(16'd100)) dut (
    .app_clk(app_clk), .arst_n(arst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_adr_i(wbs_adr_i),
    .wbs_we_i(wbs_we_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
    .tx_data_avail(tx_data_avail), .tx_data(tx_data), .tx_rd(tx_rd),
    .rx_ready(rx_ready), .rx_wr(rx_wr), .rx_data(rx_data)
  );

  always #5 app_clk = ~app_clk;

  task automatic tick();
    @(posedge app_clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic string exp_cmd(input bit we, input logic [31:0] a, input logic [31:0] d);
    if (we) return $sformatf("wm %08h %08h\n", a, d);
    return $sformatf("rm %08h\n", a);
  endfunction

  function automatic logic [31:0] model_read(input string r);
    string d = "";
    logic [7:0] c;
    for (int i = 0; i < r.len(); i++) begin
      c = r[i];
      if (c == 8'h0A) break;
      if ((c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) || (c >= 8'h41 && c <= 8'h46))
        d = $sformatf("%s%c", d, c);
    end
    if (d.len() > 8) d = d.substr(d.len() - 8, d.len() - 1);
    if (d.len() == 0) return 32'h0;
    return 32'(d.atohex());
  endfunction

  function automatic string esc(input string s);
    string r = "";
    logic [7:0] c;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      r = (c < 8'h20) ? {r, "."} : $sformatf("%s%c", r, c);
    end
    return r;
  endfunction

  function automatic string rand_reply();
    string hexs = "0123456789abcdefABCDEF";
    string junk = " \rxzgq-";
    string r = "";
    int n = $urandom_range(0, 11);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) r = $sformatf("%s%c", r, junk[$urandom_range(0, 6)]);
      r = $sformatf("%s%c", r, hexs[$urandom_range(0, 21)]);
    end
    return {r, "\n"};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tx_collect(input int gap, input int nbytes, output string s, output bit stable);
    logic [7:0] v;
    int w;
    s = "";
    stable = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      w = 0;
      while (!tx_data_avail && w < 200) begin tick(); w++; end
      if (!tx_data_avail) begin
        checks++;
        $display("FAIL tx_wait: tx_data_avail=0 after %0d cycles, wanted byte %0d", w, b);
        return;
      end
      v = tx_data;
      repeat (gap) begin
        tick();
        if (tx_data !== v || tx_data_avail !== 1'b1) stable = 1'b0;
      end
      s = $sformatf("%s%c", s, v);
      tx_rd = 1'b1;
      tick();
      tx_rd = 1'b0;
    end
  endtask

  task automatic rx_send(input string s);
    for (int i = 0; i < s.len(); i++) begin
      rx_data = s[i];
      rx_wr = 1'b1;
      tick();
      rx_wr = 1'b0;
      rx_data = 8'h00;
      if (i < s.len() - 1) repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic run_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                            input string reply, input int gap, input bit drop,
                            output string txs, output bit stable,
                            output logic ack_early, output logic ack_seen,
                            output logic [31:0] rd);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = a; wbs_dat_i = d;
    tx_collect(gap, we ? 21 : 12, txs, stable);
    if (drop) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
    rx_send(reply);
    ack_early = wbs_ack_o;
    tick();
    ack_seen = wbs_ack_o;
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 arst_n = 1'b0;
    #3;
    checks++;
    if ({tx_data_avail, tx_data, rx_ready, wbs_ack_o, wbs_err_o, wbs_dat_o} !== 44'h0)
      $display("FAIL reset_outputs: got avail=%b tx=%h rdy=%b ack=%b err=%b dat=%h, want all 0",
               tx_data_avail, tx_data, rx_ready, wbs_ack_o, wbs_err_o, wbs_dat_o);
    else passed++;
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
    checks++;
    if (rx_ready !== 1'b1 || tx_data_avail !== 1'b0)
      $display("FAIL reset_idle: got rdy=%b avail=%b, want rdy=1 avail=0", rx_ready, tx_data_avail);
    else passed++;
  endtask

  task automatic test_write_directed();
    string txs, e; bit st; logic ae, as; logic [31:0] rd;
    e = exp_cmd(1'b1, 32'h1000_0004, 32'hDEADBEEF);
    run_access(1'b1, 32'h1000_0004, 32'hDEADBEEF, "ok\n", 2, 1'b0, txs, st, ae, as, rd);
    checks++;
    if (txs != e) $display("FAIL write_tx: got '%s' want '%s'", esc(txs), esc(e)); else passed++;
    checks++;
    if (st !== 1'b1) $display("FAIL write_tx_stable: tx_data changed before tx_rd (got %b want 1)", st); else passed++;
    checks++;
    if (ae !== 1'b0 || as !== 1'b1) $display("FAIL write_ack: got early=%b ack=%b want 0/1", ae, as); else passed++;
    checks++;
    if (rd !== last_rd) $display("FAIL write_dat_o_hold: got %h want %h", rd, last_rd); else passed++;
  endtask

  task automatic test_read_directed();
    string txs, e; bit st; logic ae, as; logic [31:0] rd;
    string replies[3] = '{"\r1234ABCD\r\n", "x12\n", "9876543210\n"};
    logic [31:0] exps[3] = '{32'h1234ABCD, 32'h0000_0012, 32'h7654_3210};
    for (int i = 0; i < 3; i++) begin
      e = exp_cmd(1'b0, 32'h0000_00A0, 32'h0);
      run_access(1'b0, 32'h0000_00A0, 32'h0, replies[i], i, 1'b0, txs, st, ae, as, rd);
      last_rd = exps[i];
      checks++;
      if (txs != e) $display("FAIL read_tx[%0d]: got '%s' want '%s'", i, esc(txs), esc(e)); else passed++;
      checks++;
      if (ae !== 1'b0 || as !== 1'b1) $display("FAIL read_ack[%0d]: got early=%b ack=%b want 0/1", i, ae, as); else passed++;
      checks++;
      if (rd !== exps[i]) $display("FAIL read_data[%0d]: got %h want %h", i, rd, exps[i]); else passed++;
    end
  endtask

  task automatic test_random();
    string txs, e, rep; bit st; logic ae, as; logic [31:0] rd, a, d; bit we;
    int bad = 0;
    for (int i = 0; i < 12; i++) begin
      we = 1'($urandom_range(0, 1));
      a = $urandom; d = $urandom;
      rep = we ? "ok\n" : rand_reply();
      e = exp_cmd(we, a, d);
      run_access(we, a, d, rep, $urandom_range(0, 3), 1'b0, txs, st, ae, as, rd);
      if (!we) last_rd = model_read(rep);
      checks++;
      if (txs != e || !st || ae !== 1'b0 || as !== 1'b1 || rd !== last_rd) begin
        bad++;
        $display("FAIL random[%0d]: got tx='%s' ack=%b%b dat=%h, want tx='%s' ack=01 dat=%h reply='%s'",
                 i, esc(txs), ae, as, rd, esc(e), last_rd, esc(rep));
      end else passed++;
    end
  endtask

  task automatic test_idle_rx_and_stb_drop();
    string txs; bit st; logic ae, as; logic [31:0] rd;
    rx_send("ff\n");
    repeat (2) tick();
    checks++;
    if (tx_data_avail !== 1'b0 || wbs_ack_o !== 1'b0)
      $display("FAIL idle_rx_ignored: got avail=%b ack=%b want 0/0", tx_data_avail, wbs_ack_o);
    else passed++;
    run_access(1'b0, 32'h0000_0010, 32'h0, "5\n", 0, 1'b0, txs, st, ae, as, rd);
    last_rd = 32'h5;
    checks++;
    if (rd !== 32'h5 || as !== 1'b1) $display("FAIL idle_rx_read: got dat=%h ack=%b want 00000005/1", rd, as); else passed++;
    run_access(1'b1, 32'h0000_0020, 32'h1, "ok\n", 0, 1'b1, txs, st, ae, as, rd);
    checks++;
    if (ae !== 1'b0 || as !== 1'b0 || rd !== last_rd)
      $display("FAIL stb_drop: got ack=%b%b dat=%h want ack=00 dat=%h", ae, as, rd, last_rd);
    else passed++;
  endtask

  task automatic test_back_to_back();
    string txs, e; bit st;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_00A1;
    tx_collect(0, 12, txs, st);
    rx_send("abc\n");
    tick();
    last_rd = 32'h0000_0ABC;
    checks++;
    if (wbs_ack_o !== 1'b1 || wbs_dat_o !== last_rd)
      $display("FAIL b2b_first: got ack=%b dat=%h want 1/%h", wbs_ack_o, wbs_dat_o, last_rd);
    else passed++;
    wbs_adr_i = 32'h0000_00B2;
    tick();
    checks++;
    if (wbs_ack_o !== 1'b0 || tx_data_avail !== 1'b0)
      $display("FAIL b2b_gap: got ack=%b avail=%b want 0/0", wbs_ack_o, tx_data_avail);
    else passed++;
    tick();
    checks++;
    if (tx_data_avail !== 1'b1 || tx_data !== 8'h72)
      $display("FAIL b2b_accept: got avail=%b tx=%h want 1/72", tx_data_avail, tx_data);
    else passed++;
    e = exp_cmd(1'b0, 32'h0000_00B2, 32'h0);
    tx_collect(1, 12, txs, st);
    rx_send("7\n");
    tick();
    last_rd = 32'h7;
    checks++;
    if (txs != e || wbs_ack_o !== 1'b1 || wbs_dat_o !== last_rd)
      $display("FAIL b2b_second: got tx='%s' ack=%b dat=%h want '%s'/1/%h",
               esc(txs), wbs_ack_o, wbs_dat_o, esc(e), last_rd);
    else passed++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    string txs; bit st; int n = 0; bit acked = 1'b0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h0000_0044;
    tx_collect(0, 12, txs, st);
    while (wbs_err_o !== 1'b1 && n < 300) begin
      tick();
      n++;
      if (wbs_ack_o === 1'b1) acked = 1'b1;
    end
    checks++;
    if (n != 100) $display("FAIL timeout_latency: got err after %0d cycles want 100", n); else passed++;
    checks++;
    if (acked || wbs_dat_o !== last_rd)
      $display("FAIL timeout_noack: got acked=%b dat=%h want 0/%h", acked, wbs_dat_o, last_rd);
    else passed++;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    tick();
    checks++;
    if (wbs_err_o !== 1'b0 || rx_ready !== 1'b1 || tx_data_avail !== 1'b0)
      $display("FAIL timeout_idle: got err=%b rdy=%b avail=%b want 0/1/0", wbs_err_o, rx_ready, tx_data_avail);
    else passed++;
  endtask

  task automatic test_reset_midline();
    string txs, e; bit st; logic ae, as; logic [31:0] rd;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'hCAFE_0001; wbs_dat_i = 32'h0BAD_F00D;
    tx_collect(0, 5, txs, st);
    arst_n = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    #2;
    checks++;
    if ({tx_data_avail, tx_data, rx_ready, wbs_ack_o, wbs_err_o, wbs_dat_o} !== 44'h0)
      $display("FAIL midline_reset: got avail=%b tx=%h rdy=%b ack=%b err=%b dat=%h, want all 0",
               tx_data_avail, tx_data, rx_ready, wbs_ack_o, wbs_err_o, wbs_dat_o);
    else passed++;
    last_rd = 32'h0;
    repeat (2) tick();
    arst_n = 1'b1;
    tick();
    e = exp_cmd(1'b1, 32'hCAFE_0001, 32'h0BAD_F00D);
    run_access(1'b1, 32'hCAFE_0001, 32'h0BAD_F00D, "ok\n", 1, 1'b0, txs, st, ae, as, rd);
    checks++;
    if (txs != e || as !== 1'b1) $display("FAIL midline_resend: got '%s' ack=%b want '%s'/1", esc(txs), as, esc(e)); else passed++;
  endtask

  initial begin
    test_reset();
    test_write_directed();
    test_read_directed();
    test_random();
    test_idle_rx_and_stb_drop();
    test_back_to_back();
    test_timeout();
    test_reset_midline();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, got %0d/%0d", passed, checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
